// File: rtl/sa_bus_capture_pkg.sv
// Shared types and constants for the SA bus capture block: FSM states,
// the raw 16-bit sense-amp word and its sign-extension bit positions.
package sa_bus_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPA,
        SAMPB,
        DONE,
        HOLD
    } capState_e;

    // Raw bus layout: {SAP, SA16, SA14..SA01}
    typedef logic [15:0] saRaw_t;

    localparam int RAW_SAP_POS  = 15;
    localparam int RAW_SIGN_POS = 14;
    localparam int DATA_WIDTH   = 14;

    function automatic logic [15:0] signExtend(input saRaw_t raw);
        return {raw[RAW_SIGN_POS], raw[RAW_SIGN_POS], raw[DATA_WIDTH-1:0]};
    endfunction

endpackage

// File: rtl/sa_parity_odd.sv
// Combinational odd-parity checker over the 16-bit raw SA word.
// Only instantiated when PARITY_CHECK_EN is defined.
module sa_parity_odd
    import sa_bus_capture_pkg::*;
(
    input  saRaw_t word_i,
    output logic   odd_o
);

    assign odd_o = ^word_i;

endmodule

// File: rtl/sa_bus_capture.sv
// Captures the wire-OR SA bus after each SBF strobe, requiring two matching
// samples, and hands a sign-extended word to the G-register load path.
// Optional parity checking is built when PARITY_CHECK_EN is defined.
module sa_bus_capture
    import sa_bus_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_RETRY     = 3
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        SBF,
    input  logic        SA01,
    input  logic        SA02,
    input  logic        SA03,
    input  logic        SA04,
    input  logic        SA05,
    input  logic        SA06,
    input  logic        SA07,
    input  logic        SA08,
    input  logic        SA09,
    input  logic        SA10,
    input  logic        SA11,
    input  logic        SA12,
    input  logic        SA13,
    input  logic        SA14,
    input  logic        SA16,
    input  logic        SAP,
    output logic [15:0] WRD,
    output logic        WRDVLD,
    input  logic        WRDACK,
    output logic        PALARM,
    output logic        PFAIL,
    input  logic        CLRPAR,
    output logic        SBFOVR,
    output logic        UNSTBL
);

    capState_e   state_q, state_d;
    logic [3:0]  settleCnt_q, settleCnt_d;
    logic [2:0]  retryCnt_q, retryCnt_d;
    saRaw_t      sampA_q, sampA_d;
    logic [15:0] wrd_q, wrd_d;
    logic        wrdVld_q, wrdVld_d;
    logic        unstbl_q, unstbl_d;
    logic        sbfOvr_q, sbfOvr_d;
    logic        sbf_q, sbfPrev_q;
    logic        sbfEdge;
    logic        deliver;
    saRaw_t      rawBus;

    assign rawBus = {SAP, SA16, SA14, SA13, SA12, SA11, SA10, SA09, SA08,
                     SA07, SA06, SA05, SA04, SA03, SA02, SA01};

    assign sbfEdge = sbf_q & ~sbfPrev_q;

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q     <= IDLE;
            settleCnt_q <= '0;
            retryCnt_q  <= '0;
            sampA_q     <= '0;
            wrd_q       <= '0;
            wrdVld_q    <= 1'b0;
            unstbl_q    <= 1'b0;
            sbfOvr_q    <= 1'b0;
            sbf_q       <= 1'b0;
            sbfPrev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            settleCnt_q <= settleCnt_d;
            retryCnt_q  <= retryCnt_d;
            sampA_q     <= sampA_d;
            wrd_q       <= wrd_d;
            wrdVld_q    <= wrdVld_d;
            unstbl_q    <= unstbl_d;
            sbfOvr_q    <= sbfOvr_d;
            sbf_q       <= SBF;
            sbfPrev_q   <= sbf_q;
        end
    end

    // WRD/WRDVLD are loaded on the clock leaving SAMPB so that they are
    // already visible throughout the DONE cycle; an ack in DONE skips HOLD.
    always_comb begin
        state_d     = state_q;
        settleCnt_d = settleCnt_q;
        retryCnt_d  = retryCnt_q;
        sampA_d     = sampA_q;
        wrd_d       = wrd_q;
        wrdVld_d    = wrdVld_q;
        unstbl_d    = unstbl_q;
        sbfOvr_d    = sbfOvr_q;
        deliver     = 1'b0;

        if (sbfEdge && (state_q != IDLE)) begin
            sbfOvr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sbfEdge) begin
                    state_d     = SETTLE;
                    settleCnt_d = 4'(SETTLE_CYCLES);
                    retryCnt_d  = 3'(MAX_RETRY);
                end
            end
            SETTLE: begin
                settleCnt_d = settleCnt_q - 4'd1;
                if (settleCnt_q <= 4'd1) begin
                    state_d = SAMPA;
                end
            end
            SAMPA: begin
                sampA_d = rawBus;
                state_d = SAMPB;
            end
            SAMPB: begin
                if (sampA_q == rawBus) begin
                    deliver  = 1'b1;
                    unstbl_d = 1'b0;
                end else if (retryCnt_q != 3'd0) begin
                    retryCnt_d = retryCnt_q - 3'd1;
                    state_d    = SAMPA;
                end else begin
                    deliver  = 1'b1;
                    unstbl_d = 1'b1;
                end
            end
            DONE, HOLD: begin
                if (WRDACK) begin
                    wrdVld_d = 1'b0;
                    unstbl_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (deliver) begin
            state_d  = DONE;
            wrd_d    = signExtend(rawBus);
            wrdVld_d = 1'b1;
        end
    end

`ifdef PARITY_CHECK_EN
    logic rawOdd;
    logic palarm_q;
    logic pfail_q;

    sa_parity_odd uParity (
        .word_i(rawBus),
        .odd_o (rawOdd)
    );

    // Parity is judged on sample B, the word actually delivered; set beats CLRPAR.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            palarm_q <= 1'b0;
            pfail_q  <= 1'b0;
        end else begin
            palarm_q <= deliver & ~rawOdd;
            pfail_q  <= (deliver & ~rawOdd) | (pfail_q & ~CLRPAR);
        end
    end

    assign PALARM = palarm_q;
    assign PFAIL  = pfail_q;
`else
    logic unusedClrPar;
    assign unusedClrPar = CLRPAR;
    assign PALARM       = 1'b0;
    assign PFAIL        = 1'b0;
`endif

    assign WRD    = wrd_q;
    assign WRDVLD = wrdVld_q;
    assign SBFOVR = sbfOvr_q;
    assign UNSTBL = unstbl_q;

endmodule

// File: tb/tb_sa_bus_capture.sv
// Self-checking bench for sa_bus_capture: directed captures with a scoreboard
// of expected words, checked with immediate assertions.
module tb_sa_bus_capture;
    import sa_bus_capture_pkg::*;

    localparam int SETTLE = 4;
    localparam int RETRY  = 3;
`ifdef PARITY_CHECK_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] wrd;
        logic        unstbl;
        logic        palarm;
        int          latency;
    } expect_t;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST;
    logic        SBF;
    logic        WRDACK;
    logic        CLRPAR;
    logic [15:0] rawIn;
    logic [15:0] WRD;
    logic        WRDVLD;
    logic        PALARM;
    logic        PFAIL;
    logic        SBFOVR;
    logic        UNSTBL;

    expect_t scoreQ[$];
    int      compared   = 0;
    int      mismatched = 0;
    logic    pfailExp   = 1'b0;
    logic    sbfOvrExp  = 1'b0;

    always #5 SIM_CLK = ~SIM_CLK;

    sa_bus_capture #(
        .SETTLE_CYCLES(SETTLE),
        .MAX_RETRY    (RETRY)
    ) dut (
        .SIM_CLK(SIM_CLK),
        .SIM_RST(SIM_RST),
        .SBF    (SBF),
        .SA01   (rawIn[0]),
        .SA02   (rawIn[1]),
        .SA03   (rawIn[2]),
        .SA04   (rawIn[3]),
        .SA05   (rawIn[4]),
        .SA06   (rawIn[5]),
        .SA07   (rawIn[6]),
        .SA08   (rawIn[7]),
        .SA09   (rawIn[8]),
        .SA10   (rawIn[9]),
        .SA11   (rawIn[10]),
        .SA12   (rawIn[11]),
        .SA13   (rawIn[12]),
        .SA14   (rawIn[13]),
        .SA16   (rawIn[14]),
        .SAP    (rawIn[15]),
        .WRD    (WRD),
        .WRDVLD (WRDVLD),
        .WRDACK (WRDACK),
        .PALARM (PALARM),
        .PFAIL  (PFAIL),
        .CLRPAR (CLRPAR),
        .SBFOVR (SBFOVR),
        .UNSTBL (UNSTBL)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_wrd"},    32'(WRD),    32'h0);
        checkOutput({tag, "_wrdvld"}, 32'(WRDVLD), 32'h0);
        checkOutput({tag, "_palarm"}, 32'(PALARM), 32'h0);
        checkOutput({tag, "_pfail"},  32'(PFAIL),  32'h0);
        checkOutput({tag, "_sbfovr"}, 32'(SBFOVR), 32'h0);
        checkOutput({tag, "_unstbl"}, 32'(UNSTBL), 32'h0);
    endtask

    // Latency counts rising clocks from the SBF drive; WRDVLD should first be
    // seen after SETTLE+4 of them, plus 2 per retry.
    task automatic applyStimulus(input string tag, input logic [15:0] raw,
                                 input bit toggleSa05, input bit overrun,
                                 input logic [15:0] expWrd, input bit expUnstbl,
                                 input int expLatency);
        expect_t     e;
        expect_t     got;
        logic [15:0] rawB;
        int          lat;
        int          extraVld;
        rawB      = {raw[15], expWrd[14:0]};
        e.wrd     = expWrd;
        e.unstbl  = expUnstbl;
        e.palarm  = PARITY_ON & ~(^rawB);
        e.latency = expLatency;
        scoreQ.push_back(e);

        @(negedge SIM_CLK);
        rawIn = raw;
        @(negedge SIM_CLK);
        SBF = 1'b1;
        lat = -1;
        for (int j = 1; j <= 40 && lat < 0; j++) begin
            @(negedge SIM_CLK);
            if (WRDVLD) begin
                lat = j;
            end else begin
                if (toggleSa05) rawIn[4] = ~rawIn[4];
                if (overrun && j == 2) SBF = 1'b0;
                if (overrun && j == 4) begin
                    SBF       = 1'b1;
                    sbfOvrExp = 1'b1;
                end
            end
        end

        got = scoreQ.pop_front();
        if (got.palarm) pfailExp = 1'b1;
        checkOutput({tag, "_latency"}, 32'(lat),    32'(got.latency));
        checkOutput({tag, "_wrd"},     32'(WRD),    32'(got.wrd));
        checkOutput({tag, "_unstbl"},  32'(UNSTBL), 32'(got.unstbl));
        checkOutput({tag, "_palarm"},  32'(PALARM), 32'(got.palarm));
        checkOutput({tag, "_pfail"},   32'(PFAIL),  32'(pfailExp));
        checkOutput({tag, "_sbfovr"},  32'(SBFOVR), 32'(sbfOvrExp));

        WRDACK = 1'b1;
        @(negedge SIM_CLK);
        WRDACK = 1'b0;
        checkOutput({tag, "_vld_after_ack"},    32'(WRDVLD), 32'h0);
        checkOutput({tag, "_unstbl_after_ack"}, 32'(UNSTBL), 32'h0);
        checkOutput({tag, "_palarm_after"},     32'(PALARM), 32'h0);
        checkOutput({tag, "_wrd_hold"},         32'(WRD),    32'(got.wrd));

        extraVld = 0;
        repeat (12) begin
            @(negedge SIM_CLK);
            if (WRDVLD) extraVld++;
        end
        checkOutput({tag, "_single_vld"}, 32'(extraVld), 32'h0);
        SBF   = 1'b0;
        rawIn = '0;
        repeat (2) @(negedge SIM_CLK);
    endtask

    initial begin
        int seenVld;
        SIM_RST = 1'b1;
        SBF     = 1'b0;
        WRDACK  = 1'b0;
        CLRPAR  = 1'b0;
        rawIn   = '0;
        repeat (3) @(negedge SIM_CLK);
        SIM_RST = 1'b0;
        checkIdleOutputs("reset");

        applyStimulus("basic", 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, SETTLE + 4);

        applyStimulus("parity", 16'h0003, 1'b0, 1'b0, 16'h0003, 1'b0, SETTLE + 4);
        checkOutput("pfail_sticky", 32'(PFAIL), 32'(pfailExp));
        CLRPAR = 1'b1;
        @(negedge SIM_CLK);
        CLRPAR   = 1'b0;
        pfailExp = 1'b0;
        checkOutput("pfail_cleared", 32'(PFAIL), 32'h0);

        applyStimulus("sign", 16'h4000, 1'b0, 1'b0, 16'hC000, 1'b0, SETTLE + 4);

        // SA05 flips every cycle; the final B sample lands after 13 flips.
        applyStimulus("unstable", 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b1,
                      SETTLE + 4 + 2 * RETRY);

        applyStimulus("overrun", 16'h0005, 1'b0, 1'b1, 16'h0005, 1'b0, SETTLE + 4);

        @(negedge SIM_CLK);
        rawIn = 16'h0001;
        @(negedge SIM_CLK);
        SBF = 1'b1;
        repeat (3) @(negedge SIM_CLK);
        SIM_RST = 1'b1;
        SBF     = 1'b0;
        @(negedge SIM_CLK);
        SIM_RST   = 1'b0;
        sbfOvrExp = 1'b0;
        pfailExp  = 1'b0;
        checkIdleOutputs("midreset");
        seenVld = 0;
        repeat (15) begin
            @(negedge SIM_CLK);
            if (WRDVLD) seenVld++;
        end
        checkOutput("midreset_no_vld", 32'(seenVld), 32'h0);

        applyStimulus("after_reset", 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, SETTLE + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sa_bus_capture.md
# sa_bus_capture

Captures the wire-OR sense-amplifier bus (SA01–SA14, SA16, SAP) driven by the fixed/erasable memory stage after each SBF strobe. It waits for the flash data to settle and requires two consecutive identical samples. It checks odd parity and presents a sign-extended 16-bit word to the G-register load path through a valid/ack handshake. It sits directly downstream of the memory stage and upstream of the G-register write logic.

## Interface
Parameters:
- SETTLE_CYCLES, 4: wait cycles after the SBF edge before the first sample; legal range 1–15.
- MAX_RETRY, 3: extra sample pairs allowed when the two samples disagree; legal range 0–7.

Ports:
- SIM_CLK, input, 1: the single clock.
- SIM_RST, input, 1: synchronous, active-high reset.
- SBF, input, 1: sense-buffer strobe; a rising edge starts a capture.
- SA01..SA14, input, 1 each: data bits 1–14 from the SA bus. The bus is pulled down, so an idle line reads 0.
- SA16, input, 1: sign bit.
- SAP, input, 1: parity bit.
- WRD, output, 16: captured word, {SA16, SA16, SA14..SA01}.
- WRDVLD, output, 1: WRD is valid; held high until acked.
- WRDACK, input, 1: consumer accepts WRD.
- PALARM, output, 1: one-cycle pulse on a parity failure.
- PFAIL, output, 1: sticky parity-fail flag.
- CLRPAR, input, 1: clears PFAIL.
- SBFOVR, output, 1: sticky flag; an SBF edge arrived while the block was busy.
- UNSTBL, output, 1: the delivered word never produced two matching samples.

## Operation
- Edge detect: SBF is registered; an edge is SBF=1 with previous SBF=0.
- States:
  - IDLE: an edge moves to SETTLE and loads the counter with SETTLE_CYCLES.
  - SETTLE: decrement the counter; at 0 go to SAMPA.
  - SAMPA: latch the 16-bit raw bus {SAP, SA16, SA14..SA01} into A; go to SAMPB.
  - SAMPB: latch into B.
    - If A==B, go to DONE.
    - Else, if retries remaining > 0, decrement retries and go to SAMPA.
    - Else set UNSTBL and go to DONE using B.
  - DONE: load WRD, set WRDVLD, run the parity check; go to HOLD.
  - HOLD: wait for WRDACK; then clear WRDVLD and go to IDLE.
- Parity: the 16 bits SA01–SA14, SA16 and SAP must contain an odd number of ones.
  - Even count: PALARM pulses in the DONE cycle and PFAIL sets.
- PFAIL clears on CLRPAR; if a parity failure occurs in the same cycle, set wins.
- UNSTBL is per-word: it clears when WRDVLD drops.
- An SBF edge in any state except IDLE is ignored and sets SBFOVR. SBFOVR clears only on reset.
- SBF held high does not retrigger; only a fresh 0→1 edge does.

## Timing
- Reset values: WRD=0, WRDVLD=0, PALARM=0, PFAIL=0, SBFOVR=0, UNSTBL=0, state IDLE, previous-SBF register=0.
- Define cycle N as the edge cycle, the first clock where registered SBF=1 and previous SBF=0.
  - SETTLE occupies N+1..N+SETTLE_CYCLES.
  - Sample A is taken at N+SETTLE_CYCLES+1 and sample B at N+SETTLE_CYCLES+2.
  - With no retry, WRDVLD rises at N+SETTLE_CYCLES+3.
  - Each retry adds 2 cycles.
- WRDACK is sampled only while WRDVLD=1.
  - WRDACK high in the first valid cycle gives a one-cycle WRDVLD pulse.
  - A new edge is accepted no earlier than the cycle after WRDVLD falls.
- WRD holds its value after the ack until the next DONE.
- SIM_RST asserted in any state returns the block to IDLE on the next clock. The partial capture is discarded and all flags clear.

## Configuration
- PARITY_CHECK_EN defined: parity logic is built as described above.
- PARITY_CHECK_EN undefined: no parity logic is built.
  - PALARM and PFAIL are tied to 0 and CLRPAR is ignored.
  - SAP is still sampled for the stability comparison.

## Structure
- Shared package holds:
  - the state enum (IDLE, SETTLE, SAMPA, SAMPB, DONE, HOLD);
  - the 16-bit raw SA word typedef;
  - the sign-extension bit-position constants.
- One sub-module, sa_parity_odd: combinational 16-bit odd-parity checker, instantiated only under PARITY_CHECK_EN.

## Test plan
- Basic capture: SA01=1, SAP=0, others 0, SBF edge. Expect WRD=16'h0001 and WRDVLD at N+7; PALARM=0.
- Parity failure: SA01=SA02=1, SAP=0. Expect WRD=16'h0003, PALARM pulse, PFAIL=1; CLRPAR clears PFAIL.
- Sign extension: SA16=1, SAP=0, data 0. Expect WRD=16'hC000 and parity OK.
- Unstable bus: toggle SA05 every cycle through all samples with MAX_RETRY=3. Expect UNSTBL=1 and WRDVLD at N+13.
- Overrun: second SBF edge during SETTLE. Expect SBFOVR=1 and exactly one WRDVLD.
- Reset mid-SETTLE: SIM_RST asserted for 1 cycle. Expect all outputs 0, no WRDVLD, and the next edge captures normally.
